// File: rtl/ysyx_22041412_ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_ifq_pkg
// Description : Shared types and constants for the instruction-fetch queue:
//               fetch FSM state encoding, read-request size code and the
//               instruction word width.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_22041412_ifq_pkg;

    // Fetch sequencer states.
    //   IDLE : deciding whether a new fetch may be issued
    //   REQ  : read request presented, waiting for acceptance
    //   WAIT : request accepted, waiting for the read data
    //   DROP : a redirect made the outstanding read stale; swallow its data
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } ifq_state_e;

    // Byte-lane size code for a 32-bit word read.
    localparam logic [7:0] REQ_SIZE = 8'b0000_1111;

    // Width of one instruction word.
    localparam int INST_W = 32;

    // The read port returns a 64-bit beat; address bit 2 selects the word.
    function automatic logic [INST_W-1:0] word_sel(input logic       sel_hi,
                                                   input logic [63:0] data);
        return sel_hi ? data[63:32] : data[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041412_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_sync_fifo
// Description : Single-clock FIFO with synchronous flush. Head data is
//               presented combinationally (first-word fall-through).
//               A push when full is accepted only if a pop happens in the
//               same cycle; a pop when empty is ignored. Flush wins over
//               push and pop.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push, i_wdata - write strobe and data
//               i_pop           - remove the head entry
//               i_flush         - empty the FIFO at the next edge
//               o_rdata         - head entry (undefined while empty)
//               o_count         - number of valid entries (0..DEPTH)
//               o_full, o_empty - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041412_sync_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    input  wire logic             i_flush,
    output logic      [WIDTH-1:0] o_rdata,
    output logic      [PTR_W:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [PTR_W:0]   c_depth   = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + c_cnt_one;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - c_cnt_one;
            end
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_22041412_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_ifetch_queue
// Description : Instruction-fetch front end. Issues sequential word reads
//               (one outstanding at a time) and buffers {pc, inst} pairs in
//               a DEPTH-entry queue towards decode. A redirect flushes the
//               queue, restarts fetch at the new PC and discards the stale
//               in-flight response.
// Config      : YSYX_IFQ_BYPASS_EN - when defined, a response arriving while
//               the queue is empty is presented to decode in the same cycle
//               (and skips the queue if decode accepts it).
// Ports       : clk, rst                  - clock, synchronous active-high reset
//               redirect_i, redirect_pc_i - flush and restart fetch
//               inst_valid_o/inst_ready_i - decode handshake
//               inst_o, pc_o              - head instruction and its address
//               req_valid_o/req_ready_i   - read request handshake
//               req_addr_o, req_size_o    - read address and size code
//               resp_valid_i/resp_ready_o - read data handshake
//               resp_data_i               - 64-bit read data
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_22041412_ifetch_queue
    import ysyx_22041412_ifq_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              redirect_i,
    input  wire logic [ADDR_W-1:0] redirect_pc_i,
    output logic                   inst_valid_o,
    input  wire logic              inst_ready_i,
    output logic      [31:0]       inst_o,
    output logic      [ADDR_W-1:0] pc_o,
    output logic                   req_valid_o,
    input  wire logic              req_ready_i,
    output logic      [ADDR_W-1:0] req_addr_o,
    output logic      [7:0]        req_size_o,
    input  wire logic              resp_valid_i,
    output logic                   resp_ready_o,
    input  wire logic [63:0]       resp_data_i
);

    localparam int                CNT_W       = $clog2(DEPTH) + 1;
    localparam int                ENT_W       = ADDR_W + INST_W;
    localparam logic [CNT_W:0]    c_depth_ext = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_pc_step   = ADDR_W'(4);

    ifq_state_e        r_state;
    ifq_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic [ADDR_W-1:0] r_req_pc;
    logic [ADDR_W-1:0] w_req_pc_nxt;
    logic              r_drop_pend;
    logic              w_drop_pend_nxt;
    logic              r_req_valid;
    logic              r_resp_ready;

    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_wdata;
    logic [ENT_W-1:0]  w_rdata;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    logic              w_in_flight;
    logic [CNT_W:0]    w_occupancy;
    logic              w_credit;
    logic [INST_W-1:0] w_word;
    logic              w_resp_take;
    logic              w_bypass;
    logic              w_unused;

    // ------------------------------------------------------------------
    // Queue
    // ------------------------------------------------------------------
    ysyx_22041412_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .i_flush (redirect_i),
        .o_rdata (w_rdata),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // A slot is reserved for the outstanding read so the response can
    // always be pushed without checking for space.
    assign w_in_flight = (r_state == REQ) || (r_state == WAIT);
    assign w_occupancy = {1'b0, w_count} + {{CNT_W{1'b0}}, w_in_flight};
    assign w_credit    = (w_occupancy < c_depth_ext);

    assign w_word      = word_sel(r_req_pc[2], resp_data_i);
    assign w_wdata     = {r_req_pc, w_word};

    // A response arriving together with a redirect is already stale.
    assign w_resp_take = (r_state == WAIT) && resp_valid_i && !redirect_i;

`ifdef YSYX_IFQ_BYPASS_EN
    assign w_bypass = w_resp_take && w_empty;
    assign w_push   = w_resp_take && !(w_bypass && inst_ready_i);
`else
    assign w_bypass = 1'b0;
    assign w_push   = w_resp_take;
`endif

    // The flush on redirect makes a same-cycle pop meaningless; suppress it.
    assign w_pop = !w_empty && inst_ready_i && !redirect_i;

    // ------------------------------------------------------------------
    // Decode-side outputs (zero while nothing is valid)
    // ------------------------------------------------------------------
    always_comb begin
        inst_valid_o = !w_empty || w_bypass;
        pc_o         = '0;
        inst_o       = '0;
        if (!w_empty) begin
            {pc_o, inst_o} = w_rdata;
        end else if (w_bypass) begin
            pc_o   = r_req_pc;
            inst_o = w_word;
        end
    end

    assign req_valid_o  = r_req_valid;
    assign req_addr_o   = r_req_pc;
    assign req_size_o   = REQ_SIZE;
    assign resp_ready_o = r_resp_ready;

    // Word-aligned fetch ignores the low redirect bits; full is implied
    // by the credit check.
    assign w_unused = ^{redirect_pc_i[1:0], w_full};

    // ------------------------------------------------------------------
    // Fetch sequencer
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_fetch_pc_nxt  = r_fetch_pc;
        w_req_pc_nxt    = r_req_pc;
        w_drop_pend_nxt = r_drop_pend;

        case (r_state)
            IDLE: begin
                if (w_credit && !redirect_i) begin
                    w_state_nxt  = REQ;
                    w_req_pc_nxt = r_fetch_pc;
                end
            end
            REQ: begin
                // The request cannot be retracted; a redirect seen while it
                // waits is remembered so its data is dropped later.
                if (req_ready_i) begin
                    w_drop_pend_nxt = 1'b0;
                    if (redirect_i || r_drop_pend) begin
                        w_state_nxt = DROP;
                    end else begin
                        w_state_nxt    = WAIT;
                        w_fetch_pc_nxt = r_fetch_pc + c_pc_step;
                    end
                end else if (redirect_i) begin
                    w_drop_pend_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (resp_valid_i) begin
                    w_state_nxt = IDLE;
                end else if (redirect_i) begin
                    w_state_nxt = DROP;
                end
            end
            DROP: begin
                if (resp_valid_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (redirect_i) begin
            w_fetch_pc_nxt = {redirect_pc_i[ADDR_W-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_req_pc     <= '0;
            r_drop_pend  <= 1'b0;
            r_req_valid  <= 1'b0;
            r_resp_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fetch_pc   <= w_fetch_pc_nxt;
            r_req_pc     <= w_req_pc_nxt;
            r_drop_pend  <= w_drop_pend_nxt;
            r_req_valid  <= (w_state_nxt == REQ);
            r_resp_ready <= (w_state_nxt == WAIT) || (w_state_nxt == DROP);
        end
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22041412_ifetch_queue.md
# ysyx_22041412_ifetch_queue

Parametrised instruction-fetch front end between the PC/redirect logic and the AXI-style read port. It issues sequential word fetches from a fetch PC and decouples memory latency from decode through a DEPTH-entry instruction queue. On a branch/jump redirect it flushes the queue and discards the stale in-flight response. At most one read request is outstanding at a time.

## Interface
- ADDR_W, 32, fetch address width (≥32)
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h8000_0000, first fetch address after reset
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- redirect_i  in  1  flush queue and restart fetch at redirect_pc_i
- redirect_pc_i  in  ADDR_W  new fetch PC; bits [1:0] ignored (treated 0)
- inst_valid_o  out  1  queue head valid
- inst_ready_i  in  1  decode accepts head
- inst_o  out  32  head instruction
- pc_o  out  ADDR_W  head instruction address
- req_valid_o  out  1  read request valid
- req_ready_i  in  1  read request accepted
- req_addr_o  out  ADDR_W  read address
- req_size_o  out  8  constant 8'b0000_1111
- resp_valid_i  in  1  read data valid
- resp_ready_o  out  1  ready for read data
- resp_data_i  in  64  read data

## Operation
- Registers: fetch_pc, outstanding address req_pc, FSM state, FIFO of {pc, inst}.
- Credit: issue only when (fifo_count + in_flight) < DEPTH; in_flight = 1 in REQ/WAIT, else 0.
- FSM states:
  - IDLE: if credit and not redirect_i → REQ; req_addr_o = fetch_pc, req_pc = fetch_pc.
  - REQ: req_valid_o = 1. On req_ready_i → WAIT, fetch_pc += 4. Redirect while in REQ: req_valid_o stays high until accepted (no retraction), then → DROP.
  - WAIT: resp_ready_o = 1. On resp_valid_i → push {req_pc, word} and → IDLE. Redirect in WAIT without resp_valid_i → DROP. Redirect on the same cycle as resp_valid_i discards the response and → IDLE.
  - DROP: resp_ready_o = 1. On resp_valid_i → discard and → IDLE.
- Word select: inst = req_pc[2] ? resp_data_i[63:32] : resp_data_i[31:0].
- Pop when inst_valid_o && inst_ready_i. Simultaneous push and pop are allowed; count is unchanged.
- Redirect (any state): FIFO cleared next cycle; fetch_pc ← {redirect_pc_i[ADDR_W-1:2], 2'b00}; a pop in the same cycle is ignored.
- fetch_pc wraps modulo 2^ADDR_W.

## Timing
- Reset values: inst_valid_o 0, inst_o 0, pc_o 0, req_valid_o 0, req_addr_o 0, resp_ready_o 0; fetch_pc = RESET_PC; FSM = IDLE; FIFO empty.
- Reset mid-transaction abandons the request/response immediately. The interconnect is reset on the same rst.
- req_valid_o is registered: asserted in the cycle after the IDLE decision, so the first request appears 1 cycle after rst deasserts.
- req_addr_o is stable while req_valid_o is high.
- Response accepted at cycle t → inst_valid_o at t+1 (non-bypass). Back-to-back fetch rate: one instruction per 3 cycles plus memory latency.
- FIFO full (count == DEPTH): no issue; existing entries are held. Empty: inst_valid_o = 0.

## Configuration
- YSYX_IFQ_BYPASS_EN defined:
  - A response accepted in WAIT while the FIFO is empty and no redirect is present drives inst_valid_o/inst_o/pc_o combinationally in the same cycle.
  - If inst_ready_i is high, the word is consumed and not written to the FIFO.
  - If inst_ready_i is low, the word is pushed as normal.
- Undefined: all outputs come from the FIFO; latency is exactly +1 cycle.

## Structure
- Package ysyx_22041412_ifq_pkg:
  - FSM state enum (IDLE, REQ, WAIT, DROP).
  - REQ_SIZE = 8'b0000_1111.
  - Instruction width constant INST_W = 32.
- Sub-module ysyx_22041412_sync_fifo (parametrised WIDTH, DEPTH; push/pop/flush; count; full/empty), instantiated with WIDTH = ADDR_W + 32.

## Test plan
- Reset, memory returns 64'h0000_0013_0000_0093 every request at 2-cycle latency, inst_ready_i = 1 → pc_o sequence 8000_0000, 8000_0004, 8000_0008; inst_o 0000_0093, 0000_0013, 0000_0093.
- inst_ready_i = 0, DEPTH = 4 → exactly 4 requests issued, then req_valid_o stays 0. Raising inst_ready_i for 1 cycle → one new request.
- Redirect to 8000_0100 while in WAIT, stale response arrives 3 cycles later → stale word never appears; next pc_o = 8000_0100; FIFO empty after redirect.
- Redirect while req_valid_o is high and req_ready_i is low for 4 cycles → req_addr_o is unchanged until acceptance, that response is dropped, then a request to the new PC is issued.
- Redirect on the same cycle as resp_valid_i and a pop → response discarded, pop ignored, inst_valid_o = 0 next cycle.
- With YSYX_IFQ_BYPASS_EN and FIFO empty, response at cycle t → inst_valid_o = 1 at t with the correct inst_o; without the macro → inst_valid_o = 1 at t+1.
